match_bits_pipe: RTL and testbench

//  Parametrised, pipelined bitwise equality comparator for WIDTH-bit words a/b.
//  Per-bit XNOR match vector, popcount of matching bits, full-match flag.

---
 rtl/match_bits_pipe.sv | 154 +++++++++++++++
 tb/tb_match_bits_pipe.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/match_bits_pipe.sv
// match_bits_pipe
//   Two-stage pipelined bitwise equality comparator for WIDTH-bit words.
//   Stage 1 registers the per-bit XNOR of a/b.
//   Stage 2 registers the match vector, its popcount and a full-match flag.
//   A saturating counter tallies words that did not fully match.
//
// Optional feature (macro MATCH_BITS_ERR_CAPTURE_EN):
//   The operands travel down the pipeline. The first mismatching word after
//   reset or clr is latched into err_a/err_b and err_valid is set (sticky).
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   asynchronous reset, active-high
//   in_valid      in   a/b valid this cycle
//   a, b          in   operands, WIDTH bits
//   clr           in   synchronous clear of counter/flags (pipeline untouched)
//   out_valid     out  match/match_cnt/full_match valid (one cycle per word)
//   match         out  ~(a ^ b) of the sampled pair
//   match_cnt     out  number of set bits in match, PC_W bits
//   full_match    out  match is all ones
//   mismatch_cnt  out  saturating count of valid words with full_match == 0
//   mismatch_sat  out  sticky: mismatch_cnt reached all ones
//   err_valid     out  (feature only) a mismatching word has been captured
//   err_a, err_b  out  (feature only) operands of the captured word
module match_bits_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16,
    localparam int PC_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clr,
    output logic             out_valid,
    output logic [WIDTH-1:0] match,
    output logic [PC_W-1:0]  match_cnt,
    output logic             full_match,
    output logic [CNT_W-1:0] mismatch_cnt,
`ifdef MATCH_BITS_ERR_CAPTURE_EN
    output logic             mismatch_sat,
    output logic             err_valid,
    output logic [WIDTH-1:0] err_a,
    output logic [WIDTH-1:0] err_b
`else
    output logic             mismatch_sat
`endif
);

    logic             v1;
    logic [WIDTH-1:0] m1;
    logic [PC_W-1:0]  pc1;
    logic [CNT_W-1:0] cnt_next;
    logic             bad_word;

    // Stage 1: m1 holds its value while no word is presented.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0;
            m1 <= '0;
        end else begin
            v1 <= in_valid;
            if (in_valid) m1 <= ~(a ^ b);
        end
    end

    always_comb begin
        pc1 = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            pc1 = pc1 + PC_W'(m1[i]);
        end
    end

    // Stage 2: data outputs only move on a valid word, so they hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            match      <= '0;
            match_cnt  <= '0;
            full_match <= 1'b0;
        end else begin
            out_valid <= v1;
            if (v1) begin
                match      <= m1;
                match_cnt  <= pc1;
                full_match <= (m1 == {WIDTH{1'b1}});
            end
        end
    end

    // The counter looks at the registered stage-2 word, so it lags out_valid
    // by one cycle.
    assign bad_word = out_valid && !full_match;

    always_comb begin
        cnt_next = mismatch_cnt;
        if (bad_word && (mismatch_cnt != {CNT_W{1'b1}})) begin
            cnt_next = mismatch_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mismatch_cnt <= '0;
            mismatch_sat <= 1'b0;
        end else if (clr) begin
            mismatch_cnt <= '0;
            mismatch_sat <= 1'b0;
        end else begin
            mismatch_cnt <= cnt_next;
            if (&cnt_next) mismatch_sat <= 1'b1;
        end
    end

`ifdef MATCH_BITS_ERR_CAPTURE_EN
    logic [WIDTH-1:0] a1, b1, a2, b2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a1 <= '0;
            b1 <= '0;
            a2 <= '0;
            b2 <= '0;
        end else begin
            if (in_valid) begin
                a1 <= a;
                b1 <= b;
            end
            if (v1) begin
                a2 <= a1;
                b2 <= b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_valid <= 1'b0;
            err_a     <= '0;
            err_b     <= '0;
        end else if (clr) begin
            err_valid <= 1'b0;
            err_a     <= '0;
            err_b     <= '0;
        end else if (bad_word && !err_valid) begin
            err_valid <= 1'b1;
            err_a     <= a2;
            err_b     <= b2;
        end
    end
`endif

endmodule

// File: tb/tb_match_bits_pipe.sv
// Bench for match_bits_pipe: a default-width DUT (CNT_W=16) and a narrow-
// counter DUT (CNT_W=2) share one stimulus stream. A transaction-level model
// (queue of in-flight words with due cycles) predicts every output.
module tb_match_bits_pipe;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, in_valid, clr;
    logic [7:0] a, b;

    logic        ov1, fm1, sat1, ov2, fm2, sat2;
    logic [7:0]  m1o, m2o;
    logic [3:0]  mc1, mc2;
    logic [15:0] cnt1;
    logic [1:0]  cnt2;
`ifdef MATCH_BITS_ERR_CAPTURE_EN
    logic        ev1, ev2;
    logic [7:0]  ea1, eb1, ea2, eb2;
`endif

    match_bits_pipe #(.WIDTH(8), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .clr(clr),
        .out_valid(ov1), .match(m1o), .match_cnt(mc1), .full_match(fm1),
        .mismatch_cnt(cnt1),
`ifdef MATCH_BITS_ERR_CAPTURE_EN
        .mismatch_sat(sat1), .err_valid(ev1), .err_a(ea1), .err_b(eb1)
`else
        .mismatch_sat(sat1)
`endif
    );

    match_bits_pipe #(.WIDTH(8), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .clr(clr),
        .out_valid(ov2), .match(m2o), .match_cnt(mc2), .full_match(fm2),
        .mismatch_cnt(cnt2),
`ifdef MATCH_BITS_ERR_CAPTURE_EN
        .mismatch_sat(sat2), .err_valid(ev2), .err_a(ea2), .err_b(eb2)
`else
        .mismatch_sat(sat2)
`endif
    );

    int tests = 0;
    int fails = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model
    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         due;
    } word_t;

    word_t      q[$];
    int         cyc;
    bit         e_ov, e_fm;
    logic [7:0] e_m;
    int         e_mc;
    int         e_cnt16, e_cnt2;
    bit         e_sat16, e_sat2;
    int         inc_due;
    bit         e_ev;
    logic [7:0] e_ea, e_eb, cap_a, cap_b;

    task automatic model_reset();
        q.delete();
        e_ov = 0; e_fm = 0; e_m = '0; e_mc = 0;
        e_cnt16 = 0; e_cnt2 = 0; e_sat16 = 0; e_sat2 = 0;
        inc_due = -1;
        e_ev = 0; e_ea = '0; e_eb = '0; cap_a = '0; cap_b = '0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".out_valid"}, 64'(ov1), 64'(e_ov));
        chk({tag, ".match"}, 64'(m1o), 64'(e_m));
        chk({tag, ".match_cnt"}, 64'(mc1), 64'(e_mc));
        chk({tag, ".full_match"}, 64'(fm1), 64'(e_fm));
        chk({tag, ".cnt16"}, 64'(cnt1), 64'(e_cnt16));
        chk({tag, ".sat16"}, 64'(sat1), 64'(e_sat16));
        chk({tag, ".out_valid2"}, 64'(ov2), 64'(e_ov));
        chk({tag, ".match2"}, 64'(m2o), 64'(e_m));
        chk({tag, ".cnt2"}, 64'(cnt2), 64'(e_cnt2));
        chk({tag, ".sat2"}, 64'(sat2), 64'(e_sat2));
`ifdef MATCH_BITS_ERR_CAPTURE_EN
        chk({tag, ".err_valid"}, 64'(ev1), 64'(e_ev));
        chk({tag, ".err_a"}, 64'(ea1), 64'(e_ea));
        chk({tag, ".err_b"}, 64'(eb1), 64'(e_eb));
        chk({tag, ".err_valid2"}, 64'(ev2), 64'(e_ev));
`endif
    endtask

    // One clock: drive at negedge, sample 1 time unit after the posedge.
    task automatic step(input string tag, input bit v, input logic [7:0] va,
                        input logic [7:0] vb, input bit c);
        word_t w;
        @(negedge clk);
        in_valid = v; a = va; b = vb; clr = c;
        @(posedge clk);
        cyc++;
        #1;
        if (c) begin
            e_cnt16 = 0; e_sat16 = 0; e_cnt2 = 0; e_sat2 = 0;
            e_ev = 0; e_ea = '0; e_eb = '0;
        end else if (inc_due == cyc) begin
            if (e_cnt16 < 65535) e_cnt16++;
            if (e_cnt16 == 65535) e_sat16 = 1;
            if (e_cnt2 < 3) e_cnt2++;
            if (e_cnt2 == 3) e_sat2 = 1;
            if (!e_ev) begin
                e_ev = 1; e_ea = cap_a; e_eb = cap_b;
            end
        end
        if (q.size() > 0 && q[0].due == cyc) begin
            w = q.pop_front();
            e_ov = 1;
            e_m = ~(w.a ^ w.b);
            e_mc = $countones(e_m);
            e_fm = (e_m == 8'hFF);
            if (!e_fm) begin
                inc_due = cyc + 1;
                cap_a = w.a; cap_b = w.b;
            end
        end else begin
            e_ov = 0;
        end
        if (v) begin
            w.a = va; w.b = vb; w.due = cyc + 1;
            q.push_back(w);
        end
        check_all(tag);
    endtask

    task automatic mid_reset();
        @(negedge clk);
        in_valid = 0; clr = 0;
        #2 rst = 1;
        #1;
        model_reset();
        check_all("rst_immediate");
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        logic [7:0] ra, rb;
        bit rv, rc;
        rst = 1; in_valid = 0; clr = 0; a = '0; b = '0;
        cyc = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_all("reset_state");
        @(negedge clk) rst = 0;

        // Full match word
        step("full_in", 1, 8'hA5, 8'hA5, 0);
        step("full_lat1", 0, 8'h00, 8'h00, 0);
        chk("A5_ov", 64'(ov1), 64'd1);
        chk("A5_match", 64'(m1o), 64'hFF);
        chk("A5_cnt", 64'(mc1), 64'd8);
        chk("A5_full", 64'(fm1), 64'd1);
        step("full_lat2", 0, 8'h00, 8'h00, 0);
        chk("A5_mis_cnt", 64'(cnt1), 64'd0);

        // Fully mismatching word
        step("mis_in", 1, 8'hF0, 8'h0F, 0);
        step("mis_lat1", 0, 8'h00, 8'h00, 0);
        chk("F0_match", 64'(m1o), 64'h00);
        chk("F0_cnt", 64'(mc1), 64'd0);
        chk("F0_full", 64'(fm1), 64'd0);
        step("mis_lat2", 0, 8'h00, 8'h00, 0);
        chk("F0_mis_cnt", 64'(cnt1), 64'd1);
        step("hold", 0, 8'h00, 8'h00, 0);

        // Reset with words in flight
        step("flight1", 1, 8'h12, 8'h34, 0);
        step("flight2", 1, 8'h56, 8'h56, 0);
        mid_reset();
        repeat (3) step("post_rst", 0, 8'h00, 8'h00, 0);

        // Narrow counter saturation, clr, and clr vs increment
        step("clr0", 0, 8'h00, 8'h00, 1);
        for (int i = 0; i < 5; i++) step("sat_word", 1, 8'(i), 8'hFF, 0);
        repeat (3) step("sat_drain", 0, 8'h00, 8'h00, 0);
        chk("sat_cnt2", 64'(cnt2), 64'd3);
        chk("sat_flag2", 64'(sat2), 64'd1);
        chk("sat_cnt16", 64'(cnt1), 64'd5);
        step("sat_clr", 0, 8'h00, 8'h00, 1);
        chk("clr_cnt2", 64'(cnt2), 64'd0);
        chk("clr_sat2", 64'(sat2), 64'd0);
        step("coinc_in", 1, 8'h00, 8'h01, 0);
        step("coinc_lat", 0, 8'h00, 8'h00, 0);
        step("coinc_clr", 0, 8'h00, 8'h00, 1);
        chk("coinc_cnt2", 64'(cnt2), 64'd0);
        step("coinc_after", 0, 8'h00, 8'h00, 0);
        chk("coinc_after_cnt2", 64'(cnt2), 64'd0);

`ifdef MATCH_BITS_ERR_CAPTURE_EN
        step("err_clr", 0, 8'h00, 8'h00, 1);
        step("err_w1", 1, 8'h11, 8'h11, 0);
        step("err_w2", 1, 8'h12, 8'h13, 0);
        step("err_w3", 1, 8'hFF, 8'h00, 0);
        repeat (4) step("err_drain", 0, 8'h00, 8'h00, 0);
        chk("err_valid_c", 64'(ev1), 64'd1);
        chk("err_a_c", 64'(ea1), 64'h12);
        chk("err_b_c", 64'(eb1), 64'h13);
        step("err_clr2", 0, 8'h00, 8'h00, 1);
        chk("err_a_clr", 64'(ea1), 64'h00);
        chk("err_valid_clr", 64'(ev1), 64'd0);
`endif

        // Random streaming, back-to-back and with gaps
        for (int i = 0; i < 20000; i++) begin
            rv = ($urandom_range(0, 3) != 0);
            ra = 8'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
            rc = ($urandom_range(0, 499) == 0);
            step("rand", rv, ra, rb, rc);
            if (i == 10000) mid_reset();
        end
        repeat (3) step("rand_drain", 0, 8'h00, 8'h00, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
